xilly_hls_stream_bridge: RTL
============================

// Module: xilly_hls_stream_bridge
// PURPOSE
//  Parametrised bridge between one Xillybus write stream, one Xillybus read stream and an HLS core's
//  ap_fifo in/out ports. Replaces hand-wired FIFO + prefetch glue in the top level.
//  Adds open-driven flush, stretched HLS reset, end-of-stream EOF, word counters and sticky error flags.
// PARAMETERS
//  DATA_W    32   data width of both streams and HLS ports (8..64)
//  DEPTH     512  words per internal FIFO; power of two, >= 4
//  RST_HOLD  16   cycles hls_rst stays high after both streams are open (>= 1)
// PORTS
//  bus_clk        in   1       single clock for the whole block
//  bus_rst_n      in   1       asynchronous, active-low reset
//  user_w_open    in   1       host write stream open
//  user_w_wren    in   1       host write strobe
//  user_w_data    in   DATA_W  host write data
//  user_w_full    out  1       input FIFO full
//  user_r_open    in   1       host read stream open
//  user_r_rden    in   1       host read strobe
//  user_r_data    out  DATA_W  read data, valid the cycle after user_r_rden
//  user_r_empty   out  1       output FIFO empty
//  user_r_eof     out  1       end of stream
//  hls_rst        out  1       ap_rst for the HLS core
//  in_dout        out  DATA_W  ap_fifo input data
//  in_empty_n     out  1       in_dout valid
//  in_read        in   1       HLS consumes in_dout
//  out_din        in   DATA_W  ap_fifo output data
//  out_full_n     out  1       output FIFO can accept
//  out_write      in   1       HLS writes out_din
//  hls_done       in   1       ap_done pulse: core has produced its last word
//  status_clr     in   1       clears sticky status
//  words_in       out  32      words delivered to HLS since user_w_open rose
//  words_out      out  32      words read by host since user_r_open rose
//  status         out  3       sticky: [0] wren while full, [1] rden while empty, [2] out_write while !out_full_n
// BEHAVIOUR
//  Reset (bus_rst_n=0): FIFOs empty, in_empty_n=0, user_w_full=0, user_r_empty=1, user_r_eof=0,
//   hls_rst=1, counters=0, status=0, user_r_data=0, hold counter=RST_HOLD.
//  FIFOs: synchronous, registered read (latency 1). Write accepted iff wr_en && (!full || rd_en).
//   full = count==DEPTH; empty = count==0; pointers wrap modulo DEPTH; simultaneous rd+wr keeps count.
//  Input prefetch: fifo_rd = !in_fifo_empty && (in_read || !in_empty_n).
//   in_empty_n: 0 if !user_w_open; else 1 on fifo_rd; else 0 on in_read; else hold.
//   in_dout is the FIFO output register. words_in += 1 on each in_read && in_empty_n.
//  Output: out_full_n = !out_fifo_full. out_write when full: word dropped, status[2] set.
//   user_r_rden when empty: no pointer change, status[1] set. user_w_wren when full: dropped, status[0] set.
//   words_out += 1 on each accepted user_r_rden. Counters saturate at 2^32-1.
//  EOF: done_seen set on hls_din pulse hls_done && !hls_rst; user_r_eof = done_seen && user_r_empty, registered
//   (one cycle after the last word leaves). hls_done while hls_rst is ignored.
//  Flush: !user_w_open (sync, level) -> input FIFO and prefetch cleared, words_in=0.
//   !user_r_open -> output FIFO cleared, done_seen=0, user_r_eof=0, words_out=0.
//  hls_rst FSM: RST -> HOLD when both open (load RST_HOLD) -> RUN after RST_HOLD cycles in HOLD.
//   Any stream closing in HOLD or RUN -> RST within one cycle. hls_rst=1 in RST and HOLD.
//  status_clr has priority over a same-cycle set (clear wins).
// STRUCTURE
//  xilly_bridge_pkg: status bit indices (ST_WR_OVF, ST_RD_UNF, ST_HLS_OVF), FSM state encodings
//   (S_RST, S_HOLD, S_RUN), counter width constant.
//  One sub-module: xilly_bridge_fifo (W, DEPTH, sync flush, registered read); instantiated twice.
//  Top holds prefetch register, reset FSM, EOF logic, counters, status.
// TESTING
//  Open both, write 1..8 (DATA_W=32), HLS echoes +1 with in_read every cycle -> host reads 2..9, words_in=words_out=8.
//  Hold in_read=0 after 1 write -> in_empty_n=1 with in_dout=1 stable; 2nd word stays in FIFO until in_read.
//  DEPTH=4: write 5 words, no HLS reads -> user_w_full after 5th accepted into FIFO+prefetch, 6th sets status[0].
//  hls_done after 3 output words -> user_r_eof=0 until host reads 3rd word, then eof=1 with empty=1.
//  Open both -> hls_rst low exactly RST_HOLD=16 cycles later; drop user_r_open mid-run -> hls_rst=1 next cycle,
//   output FIFO empty, words_out=0.
//  Assert bus_rst_n=0 mid-transfer -> all outputs at reset values immediately, FIFO contents lost.

Source files
------------

// File: rtl/xilly_bridge_pkg.sv
// Shared constants, status bit map and hls_rst FSM encoding for the Xillybus <-> HLS stream bridge.
package xilly_bridge_pkg;

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned STATUS_W = 3;

    localparam int unsigned ST_WR_OVF  = 0;
    localparam int unsigned ST_RD_UNF  = 1;
    localparam int unsigned ST_HLS_OVF = 2;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } rst_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/xilly_bridge_fifo.sv
// Synchronous FIFO with registered read port and synchronous flush; full/empty flags are registered.
module xilly_bridge_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 512
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_wr;
    logic          do_rd;

    // A write into a full FIFO is still taken when a read frees a slot in the same cycle.
    always_comb begin
        do_rd     = rd_en && !empty;
        do_wr     = wr_en && (!full || rd_en);
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (do_wr && !do_rd) begin
            count_nxt = count + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                rd_data <= '0;
            end else begin
                if (do_wr) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_rd) begin
                    rd_data <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + AW'(1);
                end
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/xilly_hls_stream_bridge.sv
// Bridges a Xillybus write/read stream pair to an HLS core's ap_fifo ports, with flush on close,
// stretched HLS reset, end-of-stream EOF, word counters and sticky error flags.
module xilly_hls_stream_bridge
    import xilly_bridge_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned RST_HOLD = 16
) (
    input  logic                bus_clk,
    input  logic                bus_rst_n,
    input  logic                user_w_open,
    input  logic                user_w_wren,
    input  logic [DATA_W-1:0]   user_w_data,
    output logic                user_w_full,
    input  logic                user_r_open,
    input  logic                user_r_rden,
    output logic [DATA_W-1:0]   user_r_data,
    output logic                user_r_empty,
    output logic                user_r_eof,
    output logic                hls_rst,
    output logic [DATA_W-1:0]   in_dout,
    output logic                in_empty_n,
    input  logic                in_read,
    input  logic [DATA_W-1:0]   out_din,
    output logic                out_full_n,
    input  logic                out_write,
    input  logic                hls_done,
    input  logic                status_clr,
    output logic [CNT_W-1:0]    words_in,
    output logic [CNT_W-1:0]    words_out,
    output logic [STATUS_W-1:0] status
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

    logic                in_flush;
    logic                out_flush;
    logic                in_fifo_empty;
    logic                in_fifo_rd;
    logic                out_fifo_full;
    logic                both_open;
    logic                done_seen;
    logic [STATUS_W-1:0] status_set;

    rst_state_e          state;
    rst_state_e          state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                hls_rst_nxt;

    assign in_flush   = !user_w_open;
    assign out_flush  = !user_r_open;
    assign both_open  = user_w_open && user_r_open;
    assign out_full_n = !out_fifo_full;

    // Prefetch: refill the ap_fifo output register whenever it is empty or being consumed.
    assign in_fifo_rd = !in_fifo_empty && (in_read || !in_empty_n);

    xilly_bridge_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk     (bus_clk),
        .rst_n   (bus_rst_n),
        .flush   (in_flush),
        .wr_en   (user_w_wren),
        .wr_data (user_w_data),
        .rd_en   (in_fifo_rd),
        .rd_data (in_dout),
        .full    (user_w_full),
        .empty   (in_fifo_empty)
    );

    xilly_bridge_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk     (bus_clk),
        .rst_n   (bus_rst_n),
        .flush   (out_flush),
        .wr_en   (out_write),
        .wr_data (out_din),
        .rd_en   (user_r_rden),
        .rd_data (user_r_data),
        .full    (out_fifo_full),
        .empty   (user_r_empty)
    );

    // Flags only fire when the word is actually lost (a same-cycle drain rescues a full FIFO).
    always_comb begin
        status_set             = '0;
        status_set[ST_WR_OVF]  = user_w_wren && user_w_full && !in_fifo_rd;
        status_set[ST_RD_UNF]  = user_r_rden && user_r_empty;
        status_set[ST_HLS_OVF] = out_write && out_fifo_full && !user_r_rden;
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            in_empty_n <= 1'b0;
            done_seen  <= 1'b0;
            user_r_eof <= 1'b0;
            words_in   <= '0;
            words_out  <= '0;
            status     <= '0;
        end else begin
            if (!user_w_open) begin
                in_empty_n <= 1'b0;
            end else if (in_fifo_rd) begin
                in_empty_n <= 1'b1;
            end else if (in_read) begin
                in_empty_n <= 1'b0;
            end
            if (!user_r_open) begin
                done_seen <= 1'b0;
            end else if (hls_done && !hls_rst) begin
                done_seen <= 1'b1;
            end
            user_r_eof <= user_r_open && done_seen && user_r_empty;
            words_in   <= user_w_open ? sat_inc(words_in, in_read && in_empty_n) : '0;
            words_out  <= user_r_open ? sat_inc(words_out, user_r_rden && !user_r_empty) : '0;
            status     <= status_clr ? '0 : (status | status_set);
        end
    end

    // hls_rst sequencer: held in reset until both streams are open, then for RST_HOLD cycles more.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state    <= S_RST;
            hold_cnt <= HOLD_W'(RST_HOLD);
            hls_rst  <= 1'b1;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            hls_rst  <= hls_rst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            S_RST: begin
                if (both_open) begin
                    state_nxt = S_HOLD;
                    hold_nxt  = HOLD_W'(RST_HOLD);
                end
            end
            S_HOLD: begin
                if (!both_open) begin
                    state_nxt = S_RST;
                end else if (hold_cnt <= HOLD_W'(1)) begin
                    state_nxt = S_RUN;
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (!both_open) begin
                    state_nxt = S_RST;
                end
            end
            default: state_nxt = S_RST;
        endcase
        hls_rst_nxt = (state_nxt != S_RUN);
    end

endmodule
